i2c_byte_sequencer: RTL and testbench
=====================================

// Module: i2c_byte_sequencer
// PURPOSE
//  Upstream control stage for the I2C shift_register. It takes byte commands over a valid/ready
//  handshake and generates SCL with a clock divider. It produces START and STOP conditions and
//  drives the shift register's en_w, shift_en and rw_en once per bit. It handles the 9th (ACK)
//  bit and returns the received byte and ACK status. Single master only.
//  Clock stretching and arbitration are not supported.
// PARAMETERS
//  CLK_DIV   4   clk cycles per SCL quarter-period (>=2); one bit = 4 quarters
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  synchronous, active-high reset
//  cmd_valid      in   1  command request
//  cmd_ready      out  1  high only in IDLE; accepted when cmd_valid & cmd_ready
//  cmd_start      in   1  issue START (or repeated START) before the byte
//  cmd_stop       in   1  issue STOP after the ACK bit
//  cmd_read       in   1  1 = read byte from slave, 0 = write tx_data
//  cmd_nack       in   1  read only: 1 = master releases SDA in ACK slot (NACK), 0 = drives ACK
//  tx_data        in   8  byte to write, captured on accept
//  rx_data        out  8  byte read, valid with rx_valid, held until next read
//  rx_valid       out  1  1-cycle pulse at end of a read command
//  ack_out        out  1  write only: sampled ACK bit (0 = ACK), held until next write
//  done           out  1  1-cycle pulse when command fully complete
//  scl_out        out  1  SCL level
//  sda_oe         out  1  1 = pull SDA low, 0 = release
//  sda_in         in   1  SDA bus level
//  sr_en_w        out  1  1-cycle load pulse to shift register
//  sr_parallel_in out  8  load value: tx_data on write, 8'h00 on read
//  sr_rw_en       out  1  0 = write (shift out), 1 = read (shift in); held for the command
//  sr_shift_en    out  1  1-cycle shift pulse, once per data bit
//  sr_sda_in      out  1  sampled SDA bit presented to shift register
//  sr_sda_out     in   1  current MSB from shift register
//  sr_parallel_out in  8  shift register contents
// BEHAVIOUR
//  - Reset: state=IDLE, scl_out=1, sda_oe=0, cmd_ready=1.
//    done=rx_valid=sr_en_w=sr_shift_en=0. rx_data=8'h00, ack_out=1, sr_rw_en=0, sr_sda_in=0.
//    Divider and bit counters = 0.
//  - Reset mid-command aborts immediately, with no done pulse. The bus returns to released/SCL high
//    the next cycle.
//  - Quarter tick: a divider counts 0..CLK_DIV-1. Each quarter lasts exactly CLK_DIV cycles.
//    The divider restarts at 0 on accept.
//  - FSM: IDLE -> (cmd_start ? START : BIT) -> BIT x8 -> ACK -> (cmd_stop ? STOP : DONE) -> IDLE.
//  - Accept cycle: latch command fields and assert sr_en_w with sr_parallel_in. sr_rw_en=cmd_read.
//    cmd_ready drops the next cycle.
//  - START quarters: q0 SDA released, SCL unchanged (high from idle, low for repeated START).
//    q1 released/SCL=1; q2 SDA low/SCL=1; q3 SDA low/SCL=0.
//  - BIT/ACK quarters: SCL=0 in q0,q1 and SCL=1 in q2,q3. SDA changes only at the q0 entry.
//  - Write bit: sda_oe = ~sr_sda_out. Read bit: sda_oe=0.
//  - SDA is sampled on the last cycle of q2 into sr_sda_in. sr_shift_en pulses on the last cycle
//    of q3 of every data bit, in both modes.
//  - ACK slot, write: sda_oe=0; ack_out is loaded from the q2 sample.
//  - ACK slot, read: sda_oe = ~cmd_nack. rx_data <= sr_parallel_out, sampled at ACK q0.
//  - STOP quarters: q0 SDA low/SCL=0; q1 SDA low/SCL=1; q2,q3 released/SCL=1.
//  - DONE state lasts 1 cycle: done=1, plus rx_valid=1 if read. SCL stays at its level;
//    low if no STOP.
//  - Latency from accept to done pulse:
//    (4*[start] + 36 + 4*[stop]) * CLK_DIV + 1 cycles.
//  - cmd_valid while busy is ignored. Commands may be issued back-to-back. A new command is
//    accepted in the IDLE cycle after done.
// TESTING
//  1 CLK_DIV=4, write 8'hAB, start+stop, sda_in=0 in ACK:
//    -> sda_oe per bit 0,1,0,1,0,1,0,0; 9 SCL highs; ack_out=0; done 177 cycles after accept.
//  2 Read, start+stop, cmd_nack=1, slave bits 1,0,1,0,1,0,1,1:
//    -> rx_data=8'hAB, rx_valid with done, sda_oe=0 in ACK slot, 8 sr_shift_en pulses.
//  3 Write 8'h3C, sda_in=1 in ACK -> ack_out=1, STOP still generated, done pulse.
//  4 Write start/no-stop, then read with start:
//    -> repeated START with SDA rising while SCL low, then falling while SCL high.
//    Second command accepted the cycle after done.
//  5 rst asserted in bit 3 of a write -> next cycle scl_out=1, sda_oe=0, cmd_ready=1, no done.
//  6 cmd_valid held during a command -> no second accept until IDLE; exactly one sr_en_w per command.

Source files
------------

// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master sequencer. It turns one handshaked command into START / 8 data bits / ACK / STOP
// bus phases, and it drives the external shift register's load, shift and direction controls.
module i2c_byte_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       ack_out,
    output logic       done,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       sr_en_w,
    output logic [7:0] sr_parallel_in,
    output logic       sr_rw_en,
    output logic       sr_shift_en,
    output logic       sr_sda_in,
    input  logic       sr_sda_out,
    input  logic [7:0] sr_parallel_out
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic             stop_q;
    logic             read_q;
    logic             nack_q;
    logic             scl_q;
    logic             accept;
    logic             quarter_end;
    logic             phase_end;
    logic             sample_tick;
    logic             in_bit_slot;

    assign accept      = cmd_valid && (state == S_IDLE);
    assign quarter_end = (div_cnt == DIV_LAST);
    assign phase_end   = quarter_end && (quarter == 2'd3);
    assign sample_tick = quarter_end && (quarter == 2'd2);
    assign in_bit_slot = (state == S_BIT) || (state == S_ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Divider and quarter counters only run while the bus is being driven, so each command starts at q0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            bit_cnt <= 3'd0;
        end else if ((state == S_IDLE) || (state == S_DONE)) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            bit_cnt <= 3'd0;
        end else begin
            div_cnt <= quarter_end ? '0 : div_cnt + DIV_W'(1);
            if (quarter_end) begin
                quarter <= quarter + 2'd1;
            end
            if ((state == S_BIT) && phase_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // scl_q remembers the last driven SCL level, so an idle bus after a STOP-less command stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q    <= 1'b0;
            read_q    <= 1'b0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            rx_data   <= 8'h00;
            ack_out   <= 1'b1;
            sr_sda_in <= 1'b0;
        end else begin
            scl_q <= scl_out;
            if (accept) begin
                stop_q <= cmd_stop;
                read_q <= cmd_read;
                nack_q <= cmd_nack;
            end
            if (in_bit_slot && sample_tick) begin
                sr_sda_in <= sda_in;
            end
            if ((state == S_ACK) && sample_tick && !read_q) begin
                ack_out <= sda_in;
            end
            if ((state == S_ACK) && (quarter == 2'd0) && (div_cnt == '0) && read_q) begin
                rx_data <= sr_parallel_out;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = cmd_start ? S_START : S_BIT;
                end
            end
            S_START: begin
                if (phase_end) begin
                    state_next = S_BIT;
                end
            end
            S_BIT: begin
                if (phase_end && (bit_cnt == 3'd7)) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (phase_end) begin
                    state_next = stop_q ? S_STOP : S_DONE;
                end
            end
            S_STOP: begin
                if (phase_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus levels per quarter; the shift register's MSB changes only on the q3->q0 edge, so write SDA does too.
    always_comb begin
        cmd_ready      = (state == S_IDLE);
        scl_out        = scl_q;
        sda_oe         = 1'b0;
        sr_en_w        = accept;
        sr_parallel_in = cmd_read ? 8'h00 : tx_data;
        sr_rw_en       = accept ? cmd_read : read_q;
        sr_shift_en    = 1'b0;
        done           = 1'b0;
        rx_valid       = 1'b0;
        case (state)
            S_START: begin
                case (quarter)
                    2'd0: begin
                        scl_out = scl_q;
                        sda_oe  = 1'b0;
                    end
                    2'd1: begin
                        scl_out = 1'b1;
                        sda_oe  = 1'b0;
                    end
                    2'd2: begin
                        scl_out = 1'b1;
                        sda_oe  = 1'b1;
                    end
                    default: begin
                        scl_out = 1'b0;
                        sda_oe  = 1'b1;
                    end
                endcase
            end
            S_BIT: begin
                scl_out     = quarter[1];
                sda_oe      = read_q ? 1'b0 : ~sr_sda_out;
                sr_shift_en = phase_end;
            end
            S_ACK: begin
                scl_out = quarter[1];
                sda_oe  = read_q && !nack_q;
            end
            S_STOP: begin
                scl_out = (quarter != 2'd0);
                sda_oe  = ~quarter[1];
            end
            S_DONE: begin
                scl_out  = stop_q;
                done     = 1'b1;
                rx_valid = read_q;
            end
            default: begin
                scl_out = scl_q;
                sda_oe  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Self-checking bench for i2c_byte_sequencer: a shift-register and wired-AND SDA environment plus a
// cycle-indexed model of the bus phases, checked with directed and randomized byte commands.
module tb_i2c_byte_sequencer;

    localparam int CD = 4;
    localparam int Q4 = 4 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_nack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ack_out;
    logic       done;
    logic       scl_out;
    logic       sda_oe;
    logic       sda_in;
    logic       sr_en_w;
    logic [7:0] sr_parallel_in;
    logic       sr_rw_en;
    logic       sr_shift_en;
    logic       sr_sda_in;
    logic       sr_sda_out;
    logic [7:0] sr_parallel_out;

    logic       slave_sda = 1'b1;
    logic [7:0] sreg = 8'h00;

    int         total = 0;
    int         bad = 0;
    bit         prev_scl = 1'b1;
    logic [7:0] exp_rx = 8'h00;
    logic       exp_ack = 1'b1;

    i2c_byte_sequencer #(.CLK_DIV(CD)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .cmd_read(cmd_read),
        .cmd_nack(cmd_nack),
        .tx_data(tx_data),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .ack_out(ack_out),
        .done(done),
        .scl_out(scl_out),
        .sda_oe(sda_oe),
        .sda_in(sda_in),
        .sr_en_w(sr_en_w),
        .sr_parallel_in(sr_parallel_in),
        .sr_rw_en(sr_rw_en),
        .sr_shift_en(sr_shift_en),
        .sr_sda_in(sr_sda_in),
        .sr_sda_out(sr_sda_out),
        .sr_parallel_out(sr_parallel_out)
    );

    always #5 clk = ~clk;

    // Open-drain bus: the line is low whenever either the master or the slave pulls it.
    assign sda_in          = ~sda_oe & slave_sda;
    assign sr_sda_out      = sreg[7];
    assign sr_parallel_out = sreg;

    always @(posedge clk) begin
        if (sr_en_w === 1'b1) begin
            sreg <= sr_parallel_in;
        end else if (sr_shift_en === 1'b1) begin
            sreg <= {sreg[6:0], sr_sda_in};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            slave_sda = 1'b1;
            #1;
            checkOutput("idle_scl", 32'(scl_out), 32'(prev_scl));
            checkOutput("idle_sda_oe", 32'(sda_oe), 0);
            checkOutput("idle_ready", 32'(cmd_ready), 1);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One command from its accept cycle (c=0) to its done cycle, or to an injected reset mid-bit.
    task automatic applyStimulus(input bit start, input bit stop, input bit read, input bit nack,
                                 input logic [7:0] tx, input logic [7:0] slave_byte, input bit ack_bit,
                                 input int abort_bit);
        int base, stop_base, last_c, lat, abort_at, k, q;
        int wave_err, first_bad, done_at, en_w_cnt, shift_cnt, exp_shift;
        bit e_scl, e_sda, e_done, e_rxv;
        logic [7:0] par;
        base      = 1 + (start ? Q4 : 0);
        stop_base = base + 9 * Q4;
        lat       = stop_base + (stop ? Q4 : 0);
        abort_at  = (abort_bit >= 0) ? base + abort_bit * Q4 + CD + 1 : -1;
        last_c    = (abort_at >= 0) ? abort_at : lat;
        wave_err  = 0;
        first_bad = -1;
        done_at   = -1;
        en_w_cnt  = 0;
        shift_cnt = 0;
        par       = 8'h00;
        for (int c = 0; c <= last_c; c++) begin
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_start = start;
                cmd_stop  = stop;
                cmd_read  = read;
                cmd_nack  = nack;
                tx_data   = tx;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_start = 1'($urandom_range(0, 1));
                cmd_stop  = 1'($urandom_range(0, 1));
                cmd_read  = 1'($urandom_range(0, 1));
                cmd_nack  = 1'($urandom_range(0, 1));
                tx_data   = 8'($urandom);
            end
            slave_sda = 1'b1;
            if (c >= base && c < stop_base) begin
                k = (c - base) / Q4;
                if (k < 8 && read) slave_sda = slave_byte[7-k];
                else if (k == 8 && !read) slave_sda = ack_bit;
            end
            rst = (c == abort_at);
            #1;
            e_done = (c == lat);
            e_rxv  = (c == lat) && read;
            if (c == 0) begin
                e_scl = prev_scl;
                e_sda = 1'b0;
            end else if (c < base) begin
                q = (c - 1) / CD;
                e_scl = (q == 0) ? prev_scl : (q != 3);
                e_sda = (q >= 2);
            end else if (c < stop_base) begin
                k = (c - base) / Q4;
                q = ((c - base) % Q4) / CD;
                e_scl = (q >= 2);
                if (k < 8) e_sda = read ? 1'b0 : ~tx[7-k];
                else e_sda = read ? ~nack : 1'b0;
            end else if (c < lat) begin
                q = (c - stop_base) / CD;
                e_scl = (q != 0);
                e_sda = (q < 2);
            end else begin
                e_scl = stop;
                e_sda = 1'b0;
            end
            if (scl_out !== e_scl || sda_oe !== e_sda || cmd_ready !== (c == 0) || done !== e_done ||
                rx_valid !== e_rxv || sr_rw_en !== read) begin
                wave_err++;
                if (first_bad < 0) first_bad = c;
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (sr_en_w === 1'b1) en_w_cnt++;
            if (sr_shift_en === 1'b1) shift_cnt++;
            if (c == 0) par = sr_parallel_in;
            @(posedge clk);
            @(negedge clk);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        slave_sda = 1'b1;
        exp_shift = 0;
        for (int b = 0; b < 8; b++) begin
            if (base + b * Q4 + Q4 - 1 <= last_c) exp_shift++;
        end
        checkOutput($sformatf("waveform first_bad_cycle=%0d", first_bad), wave_err, 0);
        checkOutput("parallel_in", 32'(par), 32'(read ? 8'h00 : tx));
        checkOutput("en_w_count", en_w_cnt, 1);
        checkOutput("shift_count", shift_cnt, exp_shift);
        if (abort_at >= 0) begin
            checkOutput("abort_no_done", done_at, -1);
            checkOutput("abort_scl", 32'(scl_out), 1);
            checkOutput("abort_sda_oe", 32'(sda_oe), 0);
            checkOutput("abort_ready", 32'(cmd_ready), 1);
            prev_scl = 1'b1;
            exp_rx   = 8'h00;
            exp_ack  = 1'b1;
        end else begin
            checkOutput("latency", done_at, lat);
            prev_scl = stop;
            if (read) exp_rx = slave_byte;
            else exp_ack = ack_bit;
        end
        checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
        checkOutput("ack_out", 32'(ack_out), 32'(exp_ack));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ready", 32'(cmd_ready), 1);
        checkOutput("rst_scl", 32'(scl_out), 1);
        checkOutput("rst_sda_oe", 32'(sda_oe), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("rst_en_w", 32'(sr_en_w), 0);
        checkOutput("rst_shift_en", 32'(sr_shift_en), 0);
        checkOutput("rst_rx_data", 32'(rx_data), 0);
        checkOutput("rst_ack_out", 32'(ack_out), 1);
        checkOutput("rst_rw_en", 32'(sr_rw_en), 0);
        checkOutput("rst_sr_sda_in", 32'(sr_sda_in), 0);
        @(negedge clk);
        rst = 1'b0;
        run_idle(3);

        $display("[TB] write 0xAB with start+stop, slave ACKs");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hAB, 8'h00, 1'b0, -1);
        $display("[TB] read with start+stop and NACK, slave sends 0xAB");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'hAB, 1'b1, -1);
        $display("[TB] write 0x3C, slave NACKs");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, -1);
        run_idle(2);
        $display("[TB] write without stop, then back-to-back read with repeated start");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, -1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h96, 1'b1, -1);
        $display("[TB] reset asserted during bit 3 of a write");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 3);
        run_idle(2);

        $display("[TB] randomized commands");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1);
            run_idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
